// File: rtl/ip_tx_arb_pkg.sv
// Shared types and helpers for the frame-granular IP transmit arbiter.
// State encoding, header field widths and the round-robin step function.
package ip_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   localparam int DSCP_W   = 6;
   localparam int ECN_W    = 2;
   localparam int LEN_W    = 16;
   localparam int TTL_W    = 8;
   localparam int PROTO_W  = 8;
   localparam int ADDR_W   = 32;
   localparam int IP_HDR_W = 104;
   localparam int IDX_W    = 3;

   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
      if (int'(idx) >= n - 1) return '0;
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting one past the
// previous winner and returns a one-hot grant plus its encoded index.
module rr_arbiter
   import ip_tx_arb_pkg::*;
#(
   parameter int S_COUNT = 2
) (
   input  logic [S_COUNT-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [S_COUNT-1:0] grant_oh,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [7:0]       req_pad;
   logic [IDX_W-1:0] cand;

   always_comb begin
      req_pad   = 8'(req);
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      cand      = rr_next(last_grant, S_COUNT);
      for (int i = 0; i < S_COUNT; i++) begin
         if (!grant_vld && req_pad[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
         cand = rr_next(cand, S_COUNT);
      end
      for (int j = 0; j < S_COUNT; j++) begin
         grant_oh[j] = grant_vld && (grant_idx == j[IDX_W-1:0]);
      end
   end

endmodule

// File: rtl/ip_tx_arb_64.sv
// Frame-granular round-robin arbiter in front of the 64-bit IP transmit input.
// Optional payload-stall timeout with forced tlast and drain: IP_TX_ARB_TIMEOUT_EN.
module ip_tx_arb_64
   import ip_tx_arb_pkg::*;
#(
   parameter int S_COUNT = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [S_COUNT-1:0]          s_ip_hdr_valid,
   output logic [S_COUNT-1:0]          s_ip_hdr_ready,
   input  logic [S_COUNT*DSCP_W-1:0]   s_ip_dscp,
   input  logic [S_COUNT*ECN_W-1:0]    s_ip_ecn,
   input  logic [S_COUNT*LEN_W-1:0]    s_ip_length,
   input  logic [S_COUNT*TTL_W-1:0]    s_ip_ttl,
   input  logic [S_COUNT*PROTO_W-1:0]  s_ip_protocol,
   input  logic [S_COUNT*ADDR_W-1:0]   s_ip_source_ip,
   input  logic [S_COUNT*ADDR_W-1:0]   s_ip_dest_ip,
   input  logic [S_COUNT*64-1:0]       s_ip_payload_axis_tdata,
   input  logic [S_COUNT*8-1:0]        s_ip_payload_axis_tkeep,
   input  logic [S_COUNT-1:0]          s_ip_payload_axis_tvalid,
   output logic [S_COUNT-1:0]          s_ip_payload_axis_tready,
   input  logic [S_COUNT-1:0]          s_ip_payload_axis_tlast,
   input  logic [S_COUNT-1:0]          s_ip_payload_axis_tuser,
   output logic                        m_ip_hdr_valid,
   input  logic                        m_ip_hdr_ready,
   output logic [DSCP_W-1:0]           m_ip_dscp,
   output logic [ECN_W-1:0]            m_ip_ecn,
   output logic [LEN_W-1:0]            m_ip_length,
   output logic [TTL_W-1:0]            m_ip_ttl,
   output logic [PROTO_W-1:0]          m_ip_protocol,
   output logic [ADDR_W-1:0]           m_ip_source_ip,
   output logic [ADDR_W-1:0]           m_ip_dest_ip,
   output logic [63:0]                 m_ip_payload_axis_tdata,
   output logic [7:0]                  m_ip_payload_axis_tkeep,
   output logic                        m_ip_payload_axis_tvalid,
   input  logic                        m_ip_payload_axis_tready,
   output logic                        m_ip_payload_axis_tlast,
   output logic                        m_ip_payload_axis_tuser,
   output logic [2:0]                  grant_index,
   output logic                        busy,
   output logic                        timeout_error
);

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      grant_q, grant_d, last_q, last_d;
   logic [IP_HDR_W-1:0]   hdr_q, hdr_d, arb_hdr;
   logic                  hdr_vld_q, hdr_vld_d;
   logic [S_COUNT-1:0]    arb_oh, gnt_oh;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_vld;
   logic [63:0]           sel_tdata;
   logic [7:0]            sel_tkeep;
   logic                  sel_tvalid, sel_tlast, sel_tuser;

   rr_arbiter #(.S_COUNT(S_COUNT)) u_rr_arbiter (
      .req        (s_ip_hdr_valid),
      .last_grant (last_q),
      .grant_oh   (arb_oh),
      .grant_idx  (arb_idx),
      .grant_vld  (arb_vld)
   );

   always_comb begin
      arb_hdr = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (arb_oh[i]) begin
            arb_hdr = {s_ip_dscp[i*DSCP_W +: DSCP_W], s_ip_ecn[i*ECN_W +: ECN_W],
                       s_ip_length[i*LEN_W +: LEN_W], s_ip_ttl[i*TTL_W +: TTL_W],
                       s_ip_protocol[i*PROTO_W +: PROTO_W],
                       s_ip_source_ip[i*ADDR_W +: ADDR_W], s_ip_dest_ip[i*ADDR_W +: ADDR_W]};
         end
      end
   end

   // Payload path of the granted requester; no registers between source and sink.
   always_comb begin
      gnt_oh     = '0;
      sel_tdata  = '0;
      sel_tkeep  = '0;
      sel_tvalid = 1'b0;
      sel_tlast  = 1'b0;
      sel_tuser  = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (grant_q == i[IDX_W-1:0]) begin
            gnt_oh[i]  = 1'b1;
            sel_tdata  = s_ip_payload_axis_tdata[i*64 +: 64];
            sel_tkeep  = s_ip_payload_axis_tkeep[i*8 +: 8];
            sel_tvalid = s_ip_payload_axis_tvalid[i];
            sel_tlast  = s_ip_payload_axis_tlast[i];
            sel_tuser  = s_ip_payload_axis_tuser[i];
         end
      end
   end

`ifdef IP_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             to_fire;
   assign to_fire       = (state_q == ST_PAYLOAD) && (cnt_q == CNT_W'(TIMEOUT));
   assign timeout_error = err_q;
`else
   logic timeout_cfg_unused;
   assign timeout_cfg_unused = (TIMEOUT > 0);
   assign timeout_error      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         last_q    <= IDX_W'(S_COUNT - 1);
         hdr_q     <= '0;
         hdr_vld_q <= 1'b0;
`ifdef IP_TX_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         hdr_q     <= hdr_d;
         hdr_vld_q <= hdr_vld_d;
`ifdef IP_TX_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         err_q     <= err_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      hdr_d     = hdr_q;
      hdr_vld_d = hdr_vld_q;
`ifdef IP_TX_ARB_TIMEOUT_EN
      cnt_d     = '0;
      err_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               grant_d   = arb_idx;
               hdr_d     = arb_hdr;
               hdr_vld_d = 1'b1;
               state_d   = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (hdr_vld_q && m_ip_hdr_ready) begin
               hdr_vld_d = 1'b0;
               last_d    = grant_q;
               state_d   = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
`ifdef IP_TX_ARB_TIMEOUT_EN
            // Once the stall limit is hit the count freezes until the forced tlast is taken.
            if (to_fire) begin
               cnt_d = cnt_q;
               if (m_ip_payload_axis_tready) begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end
            end else begin
               cnt_d = sel_tvalid ? '0 : cnt_q + CNT_W'(1);
               if (sel_tvalid && m_ip_payload_axis_tready && sel_tlast) state_d = ST_IDLE;
            end
`else
            if (sel_tvalid && m_ip_payload_axis_tready && sel_tlast) state_d = ST_IDLE;
`endif
         end
`ifdef IP_TX_ARB_TIMEOUT_EN
         ST_DRAIN: begin
            if (sel_tvalid && sel_tlast) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ip_hdr_ready           = '0;
      s_ip_payload_axis_tready = '0;
      m_ip_payload_axis_tdata  = '0;
      m_ip_payload_axis_tkeep  = '0;
      m_ip_payload_axis_tvalid = 1'b0;
      m_ip_payload_axis_tlast  = 1'b0;
      m_ip_payload_axis_tuser  = 1'b0;
      case (state_q)
         ST_HEADER: s_ip_hdr_ready = gnt_oh & {S_COUNT{m_ip_hdr_ready}};
         ST_PAYLOAD: begin
`ifdef IP_TX_ARB_TIMEOUT_EN
            if (to_fire) begin
               m_ip_payload_axis_tkeep  = 8'h01;
               m_ip_payload_axis_tvalid = 1'b1;
               m_ip_payload_axis_tlast  = 1'b1;
               m_ip_payload_axis_tuser  = 1'b1;
            end else
`endif
            begin
               m_ip_payload_axis_tdata  = sel_tdata;
               m_ip_payload_axis_tkeep  = sel_tkeep;
               m_ip_payload_axis_tvalid = sel_tvalid;
               m_ip_payload_axis_tlast  = sel_tlast;
               m_ip_payload_axis_tuser  = sel_tuser;
               s_ip_payload_axis_tready = gnt_oh & {S_COUNT{m_ip_payload_axis_tready}};
            end
         end
`ifdef IP_TX_ARB_TIMEOUT_EN
         ST_DRAIN: s_ip_payload_axis_tready = gnt_oh;
`endif
         default: ;
      endcase
   end

   assign {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
           m_ip_source_ip, m_ip_dest_ip} = hdr_q;
   assign m_ip_hdr_valid = hdr_vld_q;
   assign grant_index    = grant_q;
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ip_tx_arb_64.sv
// Directed bench for ip_tx_arb_64 with two requesters; a negedge monitor
// records accepted headers/beats and compares them with hand-built frames.
module tb_ip_tx_arb_64;

   localparam int S = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [103:0] hf [S];
   logic         hv [S];
   logic [63:0]  td [S];
   logic [7:0]   tk [S];
   logic         tv [S], tl [S], tu [S];
   logic         mhr, mtr, mon_clr;

   logic [S-1:0]    s_ip_hdr_valid, s_ip_hdr_ready, s_tready;
   logic [S*6-1:0]  s_ip_dscp;
   logic [S*2-1:0]  s_ip_ecn;
   logic [S*16-1:0] s_ip_length;
   logic [S*8-1:0]  s_ip_ttl, s_ip_protocol, s_tkeep;
   logic [S*32-1:0] s_ip_source_ip, s_ip_dest_ip;
   logic [S*64-1:0] s_tdata;
   logic [S-1:0]    s_tvalid, s_tlast, s_tuser;
   logic            m_ip_hdr_valid;
   logic [5:0]      m_ip_dscp;
   logic [1:0]      m_ip_ecn;
   logic [15:0]     m_ip_length;
   logic [7:0]      m_ip_ttl, m_ip_protocol, m_tkeep;
   logic [31:0]     m_ip_source_ip, m_ip_dest_ip;
   logic [63:0]     m_tdata;
   logic            m_tvalid, m_tlast, m_tuser, busy, timeout_error;
   logic [2:0]      grant_index;
   logic [103:0]    mhdr;

   assign s_ip_hdr_valid = {hv[1], hv[0]};
   assign s_ip_dscp      = {hf[1][103:98], hf[0][103:98]};
   assign s_ip_ecn       = {hf[1][97:96], hf[0][97:96]};
   assign s_ip_length    = {hf[1][95:80], hf[0][95:80]};
   assign s_ip_ttl       = {hf[1][79:72], hf[0][79:72]};
   assign s_ip_protocol  = {hf[1][71:64], hf[0][71:64]};
   assign s_ip_source_ip = {hf[1][63:32], hf[0][63:32]};
   assign s_ip_dest_ip   = {hf[1][31:0], hf[0][31:0]};
   assign s_tdata  = {td[1], td[0]};
   assign s_tkeep  = {tk[1], tk[0]};
   assign s_tvalid = {tv[1], tv[0]};
   assign s_tlast  = {tl[1], tl[0]};
   assign s_tuser  = {tu[1], tu[0]};
   assign mhdr = {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
                  m_ip_source_ip, m_ip_dest_ip};

   ip_tx_arb_64 #(.S_COUNT(S), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
      .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
      .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
      .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
      .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
      .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
      .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
      .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(mhr),
      .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
      .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
      .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
      .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
      .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(mtr),
      .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
      .grant_index(grant_index), .busy(busy), .timeout_error(timeout_error)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [103:0] hdr_of(input int r, input logic [7:0] tag);
      return {tag[5:0], tag[7:6], 8'h00, tag, 8'd64, (r == 1) ? 8'd17 : 8'd1,
              24'h0A0000, tag, 24'hC0A801, tag};
   endfunction

   function automatic logic [127:0] beat_of(input logic [7:0] tag, input int b, input int nb,
                                            input logic [7:0] lk);
      logic       last;
      last = (b == nb - 1);
      return {54'h0, 1'b0, last, last ? lk : 8'hFF, tag, 48'h0, 8'(b)};
   endfunction

   // Monitor: accepted headers/beats, idle gaps, header stability, cross-grant ready leaks.
   logic [127:0] obs_hdr[$], obs_beat[$], exp_hdr[$], exp_beat[$];
   int           gaps[$];
   int           idle_run = 0, viol0 = 0, unstable = 0, te_cnt = 0;
   bit           armed = 1'b0, held = 1'b0;
   logic [103:0] held_hdr;

   always @(negedge clk) begin
      if (mon_clr) begin
         obs_hdr.delete(); obs_beat.delete(); gaps.delete();
         idle_run = 0; viol0 = 0; unstable = 0; armed = 1'b0; held = 1'b0;
      end else begin
         if (m_ip_hdr_valid && mhr) obs_hdr.push_back({21'h0, grant_index, mhdr});
         if (m_tvalid && mtr) obs_beat.push_back({54'h0, m_tuser, m_tlast, m_tkeep, m_tdata});
         if (m_ip_hdr_valid) begin
            if (held && mhdr !== held_hdr) unstable++;
            held     = !mhr;
            held_hdr = mhdr;
         end else held = 1'b0;
         if (busy && grant_index == 3'd1 && s_tready[0]) viol0++;
         if (timeout_error) te_cnt++;
         if (busy) begin
            if (armed && idle_run > 0) gaps.push_back(idle_run);
            idle_run = 0;
            armed    = 1'b1;
         end else idle_run++;
      end
   end

   task automatic mclr();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic exp_frame(input int r, input logic [7:0] tag, input int nb, input logic [7:0] lk);
      exp_hdr.push_back({21'h0, 3'(r), hdr_of(r, tag)});
      for (int b = 0; b < nb; b++) exp_beat.push_back(beat_of(tag, b, nb, lk));
   endtask

   task automatic sb_check(input string nm);
      chk({nm, "_nhdr"}, 128'(obs_hdr.size()), 128'(exp_hdr.size()));
      chk({nm, "_nbeat"}, 128'(obs_beat.size()), 128'(exp_beat.size()));
      for (int i = 0; i < exp_hdr.size() && i < obs_hdr.size(); i++)
         chk({nm, "_hdr"}, obs_hdr[i], exp_hdr[i]);
      for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++)
         chk({nm, "_beat"}, obs_beat[i], exp_beat[i]);
      exp_hdr.delete();
      exp_beat.delete();
   endtask

   task automatic src(input int r, input logic [7:0] tag, input int nb, input logic [7:0] lk,
                      input int stall_at, input int stall_n);
      int w;
      hf[r] = hdr_of(r, tag);
      hv[r] = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!s_ip_hdr_ready[r] && w < 300);
      if (!s_ip_hdr_ready[r]) begin
         chk("hdr_wait_bound", 128'(s_ip_hdr_ready[r]), 128'(1));
         hv[r] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      hv[r] = 1'b0;
      for (int b = 0; b < nb; b++) begin
         if (b == stall_at) begin
            tv[r] = 1'b0;
            repeat (stall_n) @(posedge clk);
            #1;
         end
         tv[r] = 1'b1;
         td[r] = {tag, 48'h0, 8'(b)};
         tk[r] = (b == nb - 1) ? lk : 8'hFF;
         tl[r] = (b == nb - 1);
         tu[r] = 1'b0;
         w = 0;
         do begin @(negedge clk); w++; end while (!s_tready[r] && w < 300);
         if (!s_tready[r]) begin
            chk("beat_wait_bound", 128'(s_tready[r]), 128'(1));
            tv[r] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      tv[r] = 1'b0;
      tl[r] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < S; i++) begin hv[i] = 1'b0; tv[i] = 1'b0; tl[i] = 1'b0; end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mhr = 1'b1; mtr = 1'b1; mon_clr = 1'b0;
      for (int i = 0; i < S; i++) begin
         hf[i] = '0; hv[i] = 1'b0; td[i] = '0; tk[i] = '0;
         tv[i] = 1'b0; tl[i] = 1'b0; tu[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
      chk("rst_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_hdr_ready", 128'(s_ip_hdr_ready), 128'(0));
      chk("rst_tready", 128'(s_tready), 128'(0));
      chk("rst_grant", 128'(grant_index), 128'(0));
      chk("rst_header", 128'(mhdr), 128'(0));
      chk("rst_timeout", 128'(timeout_error), 128'(0));
      @(posedge clk); #1 rst = 1'b0;

      // Single requester 1, 20-byte payload.
      mclr();
      exp_frame(1, 8'h31, 3, 8'h0F);
      @(posedge clk); #1;
      fork
         src(1, 8'h31, 3, 8'h0F, -1, 0);
         begin
            @(negedge clk);
            chk("t1_hv_same_cycle", 128'(m_ip_hdr_valid), 128'(0));
            @(negedge clk);
            chk("t1_hv_next", 128'(m_ip_hdr_valid), 128'(1));
            chk("t1_grant", 128'(grant_index), 128'(1));
            chk("t1_hdr_fields", 128'(mhdr), 128'(hdr_of(1, 8'h31)));
            chk("t1_busy", 128'(busy), 128'(1));
         end
      join
      @(negedge clk);
      chk("t1_busy_drop", 128'(busy), 128'(0));
      sb_check("t1");

      // Simultaneous requesters 0 and 1, two frames each.
      do_reset();
      mclr();
      exp_frame(0, 8'hA0, 2, 8'hFF);
      exp_frame(1, 8'hB0, 2, 8'hFF);
      exp_frame(0, 8'hA1, 2, 8'hFF);
      exp_frame(1, 8'hB1, 2, 8'hFF);
      fork
         begin src(0, 8'hA0, 2, 8'hFF, -1, 0); src(0, 8'hA1, 2, 8'hFF, -1, 0); end
         begin src(1, 8'hB0, 2, 8'hFF, -1, 0); src(1, 8'hB1, 2, 8'hFF, -1, 0); end
      join
      @(negedge clk);
      chk("t2_ngaps", 128'(gaps.size()), 128'(3));
      for (int i = 0; i < gaps.size(); i++) chk("t2_gap", 128'(gaps[i]), 128'(1));
      sb_check("t2");

      // Downstream backpressure: header held off, then tready every other cycle.
      do_reset();
      mclr();
      mhr = 1'b0;
      mtr = 1'b0;
      exp_frame(1, 8'hC0, 4, 8'hFF);
      exp_frame(0, 8'hC1, 2, 8'h03);
      fork
         src(1, 8'hC0, 4, 8'hFF, -1, 0);
         begin repeat (3) @(posedge clk); #1; src(0, 8'hC1, 2, 8'h03, -1, 0); end
         begin repeat (10) @(posedge clk); #1 mhr = 1'b1; end
         begin for (int k = 0; k < 80; k++) begin @(posedge clk); #1 mtr = (k % 2 == 1); end end
      join
      mtr = 1'b1;
      @(negedge clk);
      chk("t3_hdr_stable", 128'(unstable), 128'(0));
      chk("t3_req0_tready_leak", 128'(viol0), 128'(0));
      sb_check("t3");

      // Reset during beat 2 of a 5-beat frame.
      do_reset();
      mclr();
      @(posedge clk); #1;
      hf[1] = hdr_of(1, 8'h4A);
      hv[1] = 1'b1;
      repeat (2) @(negedge clk);
      chk("t4_hdr_ready", 128'(s_ip_hdr_ready[1]), 128'(1));
      @(posedge clk); #1;
      hv[1] = 1'b0; tv[1] = 1'b1; td[1] = 64'hA0; tk[1] = 8'hFF; tl[1] = 1'b0;
      @(negedge clk);
      chk("t4_beat1", 128'(m_tdata), 128'(64'hA0));
      @(posedge clk); #1 td[1] = 64'hA1;
      @(negedge clk);
      chk("t4_beat2", 128'(m_tdata), 128'(64'hA1));
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("t4_busy", 128'(busy), 128'(0));
      chk("t4_tvalid", 128'(m_tvalid), 128'(0));
      chk("t4_tready", 128'(s_tready), 128'(0));
      chk("t4_hdr_valid", 128'(m_ip_hdr_valid), 128'(0));
      @(posedge clk); #1;
      tv[1] = 1'b0;
      hf[0] = hdr_of(0, 8'h40);
      hv[0] = 1'b1;
      hv[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t4_regrant_valid", 128'(m_ip_hdr_valid), 128'(1));
      chk("t4_regrant_idx", 128'(grant_index), 128'(0));
      chk("t4_regrant_hdr", 128'(mhdr), 128'(hdr_of(0, 8'h40)));
      do_reset();

`ifdef IP_TX_ARB_TIMEOUT_EN
      // Requester 0 stalls mid-frame past the limit; requester 1 waits behind it.
      mclr();
      exp_hdr.push_back({21'h0, 3'd0, hdr_of(0, 8'hE0)});
      exp_beat.push_back(beat_of(8'hE0, 0, 4, 8'hFF));
      exp_beat.push_back(beat_of(8'hE0, 1, 4, 8'hFF));
      exp_beat.push_back({54'h0, 1'b1, 1'b1, 8'h01, 64'h0});
      exp_frame(1, 8'hE1, 1, 8'hFF);
      fork
         src(0, 8'hE0, 4, 8'hFF, 2, 30);
         begin repeat (4) @(posedge clk); #1; src(1, 8'hE1, 1, 8'hFF, -1, 0); end
      join
      @(negedge clk);
      sb_check("t5");
      chk("t5_timeout_pulses", 128'(te_cnt), 128'(1));
`else
      chk("no_timeout_pulses", 128'(te_cnt), 128'(0));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
